// File: rtl/bch_corr_pkg.sv
// Shared definitions for the serial BCH error corrector: FSM encoding and
// the width helper used to size the position and correction counters.
package bch_corr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_sat_cnt.sv
// Saturating counter with synchronous clear-to-value and increment; also
// exposes the next value so callers can see a count that includes this cycle.
module bch_sat_cnt #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic [W-1:0] init,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = init;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/bch_err_corrector_ser.sv
// Serial BCH correction stage: flips each received bit flagged by the Chien
// search, counts corrections and reports success/failure per codeword.
module bch_err_corrector_ser
  import bch_corr_pkg::*;
#(
  parameter  int CODEWORD_LEN = 15,
  parameter  int T            = 2,
  localparam int POS_W        = clog2(CODEWORD_LEN),
  localparam int CNT_W        = clog2(T + 2)
) (
  input  logic             clk,
  input  logic             in_ctr_Srst,
  input  logic             in_ctr_en,
  input  logic             in_ctr_start,
  input  logic             in_rcv_bit,
  input  logic             in_err_loc,
  input  logic [CNT_W-1:0] in_err_cnt,
  output logic             out_bit,
  output logic             out_vld,
  output logic             out_first,
  output logic             out_last,
  output logic             out_done,
  output logic             out_fail,
  output logic [CNT_W-1:0] out_corr_cnt,
  output logic             out_abort,
  output state_e           dbg_state
);

  // Stream handshake: a bit is consumed only when in_ctr_en is high and the
  // block is either mid-codeword or being told this is bit 0; there is no
  // backpressure, so upstream must hold in_ctr_en low to stall.

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             out_bit_q, out_bit_d;
  logic             out_vld_q, out_vld_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic             out_done_q, out_done_d;
  logic             out_fail_q, out_fail_d;
  logic [CNT_W-1:0] out_corr_cnt_q, out_corr_cnt_d;
  logic             out_abort_q, out_abort_d;

  logic             accept;
  logic [POS_W-1:0] cur_pos;
  logic [CNT_W-1:0] ccnt;
  logic [CNT_W-1:0] ccnt_nxt;

  assign accept  = in_ctr_en && ((state_q == RUN) || in_ctr_start);
  assign cur_pos = in_ctr_start ? '0 : pos_q;

  bch_sat_cnt #(
    .W   (CNT_W),
    .MAX (T + 1)
  ) u_ccnt (
    .clk     (clk),
    .srst    (in_ctr_Srst),
    .clr     (accept && in_ctr_start),
    .init    (CNT_W'(in_err_loc)),
    .inc     (accept && !in_ctr_start && in_err_loc),
    .cnt     (ccnt),
    .cnt_nxt (ccnt_nxt)
  );

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    err_cnt_d      = err_cnt_q;
    out_bit_d      = out_bit_q;
    out_vld_d      = 1'b0;
    out_first_d    = 1'b0;
    out_last_d     = 1'b0;
    out_done_d     = 1'b0;
    out_fail_d     = out_fail_q;
    out_corr_cnt_d = out_corr_cnt_q;
    out_abort_d    = 1'b0;
    if (accept) begin
      out_vld_d   = 1'b1;
      out_bit_d   = in_rcv_bit ^ in_err_loc;
      out_first_d = (cur_pos == '0);
      out_last_d  = (cur_pos == POS_W'(CODEWORD_LEN - 1));
      if (in_ctr_start) begin
        // A start while running truncates the current codeword.
        out_abort_d = (state_q == RUN);
        err_cnt_d   = in_err_cnt;
        pos_d       = POS_W'(1);
        state_d     = RUN;
      end else if (pos_q == POS_W'(CODEWORD_LEN - 1)) begin
        state_d        = IDLE;
        pos_d          = '0;
        out_done_d     = 1'b1;
        out_corr_cnt_d = ccnt_nxt;
        out_fail_d     = (ccnt_nxt != err_cnt_q) || (err_cnt_q > CNT_W'(T));
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      state_q        <= IDLE;
      pos_q          <= '0;
      err_cnt_q      <= '0;
      out_bit_q      <= 1'b0;
      out_vld_q      <= 1'b0;
      out_first_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_done_q     <= 1'b0;
      out_fail_q     <= 1'b0;
      out_corr_cnt_q <= '0;
      out_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      err_cnt_q      <= err_cnt_d;
      out_bit_q      <= out_bit_d;
      out_vld_q      <= out_vld_d;
      out_first_q    <= out_first_d;
      out_last_q     <= out_last_d;
      out_done_q     <= out_done_d;
      out_fail_q     <= out_fail_d;
      out_corr_cnt_q <= out_corr_cnt_d;
      out_abort_q    <= out_abort_d;
    end
  end

  assign out_bit      = out_bit_q;
  assign out_vld      = out_vld_q;
  assign out_first    = out_first_q;
  assign out_last     = out_last_q;
  assign out_done     = out_done_q;
  assign out_fail     = out_fail_q;
  assign out_corr_cnt = out_corr_cnt_q;
  assign out_abort    = out_abort_q;
  assign dbg_state    = state_q;

  // The live count is only consumed through ccnt_nxt at the last position.
  logic unused_ccnt;
  assign unused_ccnt = ^ccnt;

endmodule

// File: tb/tb_bch_err_corrector_ser.sv
// Directed bench for the serial BCH corrector at N=15, T=2: each task drives
// one scenario and compares the captured outputs with hand-computed values.
module tb_bch_err_corrector_ser;
  import bch_corr_pkg::*;

  localparam int CNT_W = 2;

  logic             clk;
  logic             in_ctr_Srst;
  logic             in_ctr_en;
  logic             in_ctr_start;
  logic             in_rcv_bit;
  logic             in_err_loc;
  logic [CNT_W-1:0] in_err_cnt;
  logic             out_bit;
  logic             out_vld;
  logic             out_first;
  logic             out_last;
  logic             out_done;
  logic             out_fail;
  logic [CNT_W-1:0] out_corr_cnt;
  logic             out_abort;
  state_e           dbg_state;

  int checks;
  int errors;

  // Captured per-codeword observations.
  int          obs_vld;
  int          obs_idle_vld;
  int          obs_done;
  int          obs_done_at;
  int          obs_abort;
  int          obs_fl_bad;
  logic [14:0] obs_word;
  logic [1:0]  obs_corr;
  logic        obs_fail;
  logic [0:0]  exp_q[$];

  bch_err_corrector_ser #(
    .CODEWORD_LEN (15),
    .T            (2)
  ) dut (
    .clk          (clk),
    .in_ctr_Srst  (in_ctr_Srst),
    .in_ctr_en    (in_ctr_en),
    .in_ctr_start (in_ctr_start),
    .in_rcv_bit   (in_rcv_bit),
    .in_err_loc   (in_err_loc),
    .in_err_cnt   (in_err_cnt),
    .out_bit      (out_bit),
    .out_vld      (out_vld),
    .out_first    (out_first),
    .out_last     (out_last),
    .out_done     (out_done),
    .out_fail     (out_fail),
    .out_corr_cnt (out_corr_cnt),
    .out_abort    (out_abort),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle; returns #1 after the edge so outputs reflect it.
  task automatic step(input logic en, input logic st, input logic rb,
                      input logic el, input logic [1:0] ec);
    in_ctr_en    = en;
    in_ctr_start = st;
    in_rcv_bit   = rb;
    in_err_loc   = el;
    in_err_cnt   = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_vld      = 0;
    obs_idle_vld = 0;
    obs_done     = 0;
    obs_done_at  = -1;
    obs_abort    = 0;
    obs_fl_bad   = 0;
    obs_word     = '0;
    obs_corr     = '0;
    obs_fail     = 1'b0;
    exp_q.delete();
  endtask

  task automatic sample(input logic en_cycle);
    if (out_vld) begin
      if (!en_cycle) obs_idle_vld++;
      if (obs_vld < 15) obs_word[obs_vld] = out_bit;
      if (out_first !== (obs_vld == 0)) obs_fl_bad++;
      if (out_last !== (obs_vld == 14)) obs_fl_bad++;
      obs_vld++;
    end
    if (out_done) begin
      obs_done++;
      obs_done_at = obs_vld;
      obs_corr    = out_corr_cnt;
      obs_fail    = out_fail;
    end
    if (out_abort) obs_abort++;
  endtask

  // Feed one full codeword; gap en=0 cycles (carrying start/loc noise) follow each bit but the last.
  task automatic run_cw(input logic [1:0] ec, input logic [14:0] loc,
                        input logic [14:0] rcv, input int gap);
    clear_obs();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, (i == 0), rcv[i], loc[i], ec);
      sample(1'b1);
      if (i < 14) begin
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)));
          sample(1'b0);
        end
      end
    end
  endtask

  task automatic test_reset();
    in_ctr_Srst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
    checks++;
    if ({out_bit, out_vld, out_first, out_last, out_done, out_fail, out_corr_cnt, out_abort} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {out_bit, out_vld, out_first, out_last, out_done, out_fail, out_corr_cnt, out_abort});
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want IDLE", dbg_state);
    end
    in_ctr_Srst = 1'b0;
  endtask

  task automatic test_idle_ignore();
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
      sample(1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
    sample(1'b0);
    checks++;
    if ((obs_vld + obs_done + obs_abort) !== 0) begin
      errors++;
      $display("FAIL idle_ignore got vld=%0d done=%0d abort=%0d want 0", obs_vld, obs_done, obs_abort);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL idle_state got %0d want IDLE", dbg_state);
    end
  endtask

  task automatic test_all_zero();
    run_cw(2'd0, 15'h0000, 15'h0000, 0);
    checks++;
    if (obs_vld !== 15 || obs_fl_bad !== 0) begin
      errors++;
      $display("FAIL zero_vld got vld=%0d fl_bad=%0d want 15/0", obs_vld, obs_fl_bad);
    end
    checks++;
    if (obs_word !== 15'h0000) begin
      errors++;
      $display("FAIL zero_word got %h want 0000", obs_word);
    end
    checks++;
    if (obs_done !== 1 || obs_done_at !== 15 || obs_corr !== 2'd0 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%0d at=%0d corr=%0d fail=%b want 1/15/0/0", obs_done, obs_done_at, obs_corr, obs_fail);
    end
  endtask

  task automatic test_two_errors();
    run_cw(2'd2, 15'h0808, 15'h0008, 0);
    checks++;
    if (obs_word !== 15'h0800) begin
      errors++;
      $display("FAIL two_err_word got %h want 0800", obs_word);
    end
    checks++;
    if (obs_done !== 1 || obs_corr !== 2'd2 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL two_err_done got done=%0d corr=%0d fail=%b want 1/2/0", obs_done, obs_corr, obs_fail);
    end
    // Hit at bit 0 loads the counter on start.
    run_cw(2'd2, 15'h0101, 15'h5A3C, 0);
    checks++;
    if (obs_word !== 15'h5B3D || obs_corr !== 2'd2 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL pos0_err got word=%h corr=%0d fail=%b want 5b3d/2/0", obs_word, obs_corr, obs_fail);
    end
    run_cw(2'd1, 15'h0101, 15'h5A3C, 0);
    checks++;
    if (obs_corr !== 2'd2 || obs_fail !== 1'b1) begin
      errors++;
      $display("FAIL cnt_mismatch got corr=%0d fail=%b want 2/1", obs_corr, obs_fail);
    end
  endtask

  task automatic test_fail_sat();
    run_cw(2'd3, 15'h0421, 15'h0000, 0);
    checks++;
    if (obs_word !== 15'h0421 || obs_corr !== 2'd3 || obs_fail !== 1'b1) begin
      errors++;
      $display("FAIL three_hits got word=%h corr=%0d fail=%b want 0421/3/1", obs_word, obs_corr, obs_fail);
    end
    run_cw(2'd2, 15'h4211, 15'h7FFF, 0);
    checks++;
    if (obs_word !== 15'h3DEE || obs_corr !== 2'd3 || obs_fail !== 1'b1) begin
      errors++;
      $display("FAIL four_hits_sat got word=%h corr=%0d fail=%b want 3dee/3/1", obs_word, obs_corr, obs_fail);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    checks++;
    if (out_corr_cnt !== 2'd3 || out_fail !== 1'b1 || out_done !== 1'b0) begin
      errors++;
      $display("FAIL result_hold got corr=%0d fail=%b done=%b want 3/1/0", out_corr_cnt, out_fail, out_done);
    end
  endtask

  task automatic test_en_toggle();
    logic [14:0] rcv;
    logic [14:0] loc;
    int          mism;
    rcv  = 15'h1234;
    loc  = 15'h0808;
    for (int i = 0; i < 15; i++) exp_q.push_back(rcv[i] ^ loc[i]);
    begin
      logic [0:0] saved[$];
      saved = exp_q;
      run_cw(2'd2, loc, rcv, 1);
      exp_q = saved;
    end
    mism = 0;
    for (int i = 0; i < 15; i++) begin
      if (obs_word[i] !== exp_q.pop_front()) mism++;
    end
    checks++;
    if (obs_vld !== 15 || obs_idle_vld !== 0) begin
      errors++;
      $display("FAIL toggle_vld got vld=%0d idle_vld=%0d want 15/0", obs_vld, obs_idle_vld);
    end
    checks++;
    if (mism !== 0 || obs_fl_bad !== 0) begin
      errors++;
      $display("FAIL toggle_bits got word=%h fl_bad=%0d want 1a3c/0", obs_word, obs_fl_bad);
    end
    checks++;
    if (obs_done !== 1 || obs_abort !== 0 || obs_corr !== 2'd2 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done got done=%0d abort=%0d corr=%0d fail=%b want 1/0/2/0", obs_done, obs_abort, obs_corr, obs_fail);
    end
  endtask

  task automatic test_abort();
    int part_done;
    int part_vld;
    part_done = 0;
    part_vld  = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i == 0), 1'b0, (i == 2), 2'd1);
      if (out_done) part_done++;
      if (out_vld) part_vld++;
    end
    run_cw(2'd1, 15'h2000, 15'h0001, 0);
    checks++;
    if (part_vld !== 7 || part_done !== 0) begin
      errors++;
      $display("FAIL abort_partial got vld=%0d done=%0d want 7/0", part_vld, part_done);
    end
    checks++;
    if (obs_abort !== 1) begin
      errors++;
      $display("FAIL abort_pulse got %0d want 1", obs_abort);
    end
    checks++;
    if (obs_done !== 1 || obs_done_at !== 15 || obs_vld !== 15 || obs_fl_bad !== 0) begin
      errors++;
      $display("FAIL abort_restart got done=%0d at=%0d vld=%0d fl_bad=%0d want 1/15/15/0", obs_done, obs_done_at, obs_vld, obs_fl_bad);
    end
    checks++;
    if (obs_word !== 15'h2001 || obs_corr !== 2'd1 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL abort_result got word=%h corr=%0d fail=%b want 2001/1/0", obs_word, obs_corr, obs_fail);
    end
  endtask

  task automatic test_back_to_back();
    run_cw(2'd1, 15'h4000, 15'h0000, 0);
    checks++;
    if (obs_done !== 1 || obs_corr !== 2'd1 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got done=%0d corr=%0d fail=%b want 1/1/0", obs_done, obs_corr, obs_fail);
    end
    run_cw(2'd0, 15'h0000, 15'h6AAA, 0);
    checks++;
    if (obs_vld !== 15 || obs_abort !== 0 || obs_done !== 1 || obs_word !== 15'h6AAA || obs_corr !== 2'd0) begin
      errors++;
      $display("FAIL b2b_second got vld=%0d abort=%0d done=%0d word=%h corr=%0d want 15/0/1/6aaa/0", obs_vld, obs_abort, obs_done, obs_word, obs_corr);
    end
  endtask

  task automatic test_reset_mid();
    int late;
    run_cw(2'd1, 15'h0110, 15'h0000, 0);
    checks++;
    if (out_fail !== 1'b1 || out_corr_cnt !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset got fail=%b corr=%0d want 1/2", out_fail, out_corr_cnt);
    end
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1, 1'b1, 2'd2);
    in_ctr_Srst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    in_ctr_Srst = 1'b0;
    checks++;
    if ({out_bit, out_vld, out_first, out_last, out_done, out_fail, out_corr_cnt, out_abort} !== 9'd0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset_clear got %b state=%0d want 0/IDLE", {out_bit, out_vld, out_first, out_last, out_done, out_fail, out_corr_cnt, out_abort}, dbg_state);
    end
    late = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
      if (out_done || out_vld || out_abort) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL mid_reset_silent got %0d active cycles want 0", late);
    end
    run_cw(2'd0, 15'h0000, 15'h7FFF, 0);
    checks++;
    if (obs_done !== 1 || obs_abort !== 0 || obs_word !== 15'h7FFF || obs_corr !== 2'd0 || obs_fail !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_cw got done=%0d abort=%0d word=%h corr=%0d fail=%b want 1/0/7fff/0/0", obs_done, obs_abort, obs_word, obs_corr, obs_fail);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    in_ctr_Srst  = 1'b1;
    in_ctr_en    = 1'b0;
    in_ctr_start = 1'b0;
    in_rcv_bit   = 1'b0;
    in_err_loc   = 1'b0;
    in_err_cnt   = '0;
    clear_obs();
    test_reset();
    test_idle_ignore();
    test_all_zero();
    test_two_errors();
    test_fail_sat();
    test_en_toggle();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
